// File: rtl/mouse_ps2_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the mouse.
// It captures the device ACK and completes the request with a toggle handshake.
module mouse_ps2_tx #(
  parameter bit          ODD_PARITY = 1'b1,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic               mouse_clk,
  input  logic               reset,
  input  logic               ps2_data_in,
  output logic               ps2_data_oe,
  input  logic [7:0]         cmd_data,
  input  logic               tx_req_toggle,
  output logic               tx_done_toggle,
  output logic               busy,
  output logic               ack_error,
  output logic [COUNT_W-1:0] frame_count,
  output logic [COUNT_W-1:0] error_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_ACK    = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic [2:0] bit_idx_q;
  logic       req_seen_q;

  logic pending;
  logic ack_done;
  logic launchable;

  assign pending    = (tx_req_toggle != req_seen_q);
  assign ack_done   = (state_q == S_ACK) && (tx_done_toggle == req_seen_q);
  assign launchable = (state_q == S_IDLE) || ack_done;

  // Frame sequencer: the host changes data while the device clock is low.
  always_ff @(negedge mouse_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      bit_idx_q  <= 3'd0;
      req_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_DATA: begin
          shreg_q   <= {1'b0, shreg_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_q <= S_PARITY;
          end
        end
        S_PARITY: state_q <= S_STOP;
        S_STOP:   state_q <= S_ACK;
        default: begin
          // IDLE, or ACK once its result is captured: both can launch directly.
          if (launchable && pending) begin
            shreg_q    <= cmd_data;
            par_q      <= ODD_PARITY ? ~^cmd_data : ^cmd_data;
            bit_idx_q  <= 3'd0;
            req_seen_q <= tx_req_toggle;
            state_q    <= S_DATA;
          end else if (ack_done) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // ACK capture and completion on the device's rising edge.
  always_ff @(posedge mouse_clk or posedge reset) begin
    if (reset) begin
      tx_done_toggle <= 1'b0;
      ack_error      <= 1'b0;
      frame_count    <= '0;
      error_count    <= '0;
    end else if ((state_q == S_ACK) && (tx_done_toggle != req_seen_q)) begin
      tx_done_toggle <= req_seen_q;
      ack_error      <= ps2_data_in;
      frame_count    <= frame_count + COUNT_W'(1);
      if (ps2_data_in) begin
        error_count <= error_count + COUNT_W'(1);
      end
    end
  end

  // Open-drain drive; only the start-bit term looks at a non-register input.
  always_comb begin
    ps2_data_oe = 1'b0;
    case (state_q)
      S_IDLE:   ps2_data_oe = pending;
      S_DATA:   ps2_data_oe = ~shreg_q[0];
      S_PARITY: ps2_data_oe = ~par_q;
      S_STOP:   ps2_data_oe = 1'b0;
      S_ACK:    ps2_data_oe = ack_done && pending;
      default:  ps2_data_oe = 1'b0;
    endcase
    if (reset) begin
      ps2_data_oe = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE) && !ack_done;

endmodule

// File: tb/tb_mouse_ps2_tx.sv
// Bench for mouse_ps2_tx: a device BFM clocks frames, decodes the line and
// answers ACK/NACK. An odd-parity and an even-parity instance run side by side.
module tb_mouse_ps2_tx;

  localparam int unsigned CW = 8;

  logic          mouse_clk;
  logic          reset;
  logic          tx_req_toggle;
  logic [7:0]    cmd_data;
  logic          dev_low;
  logic          oe_o, oe_e, din_o, din_e;
  logic          done_o, done_e, busy_o, busy_e, aerr_o, aerr_e;
  logic [CW-1:0] fc_o, fc_e, ec_o, ec_e;

  // Wired-AND data line: host pulls low via oe, device pulls low for ACK.
  assign din_o = ~(oe_o | dev_low);
  assign din_e = ~(oe_e | dev_low);

  mouse_ps2_tx #(.ODD_PARITY(1'b1), .COUNT_W(CW)) dut_o (
    .mouse_clk(mouse_clk), .reset(reset), .ps2_data_in(din_o), .ps2_data_oe(oe_o),
    .cmd_data(cmd_data), .tx_req_toggle(tx_req_toggle), .tx_done_toggle(done_o),
    .busy(busy_o), .ack_error(aerr_o), .frame_count(fc_o), .error_count(ec_o)
  );

  mouse_ps2_tx #(.ODD_PARITY(1'b0), .COUNT_W(CW)) dut_e (
    .mouse_clk(mouse_clk), .reset(reset), .ps2_data_in(din_e), .ps2_data_oe(oe_e),
    .cmd_data(cmd_data), .tx_req_toggle(tx_req_toggle), .tx_done_toggle(done_e),
    .busy(busy_e), .ack_error(aerr_e), .frame_count(fc_e), .error_count(ec_e)
  );

  int            vectors;
  int            miscompares;
  logic          m_done;
  logic          m_err;
  logic [CW-1:0] m_fc;
  logic [CW-1:0] m_ec;
  logic [9:0]    oe_seen_o, oe_seen_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag, input logic exp_busy);
    chk({tag, ".done_o"}, 32'(done_o), 32'(m_done));
    chk({tag, ".done_e"}, 32'(done_e), 32'(m_done));
    chk({tag, ".aerr_o"}, 32'(aerr_o), 32'(m_err));
    chk({tag, ".aerr_e"}, 32'(aerr_e), 32'(m_err));
    chk({tag, ".fc_o"},   32'(fc_o),   32'(m_fc));
    chk({tag, ".fc_e"},   32'(fc_e),   32'(m_fc));
    chk({tag, ".ec_o"},   32'(ec_o),   32'(m_ec));
    chk({tag, ".ec_e"},   32'(ec_e),   32'(m_ec));
    chk({tag, ".busy_o"}, 32'(busy_o), 32'(exp_busy));
    chk({tag, ".busy_e"}, 32'(busy_e), 32'(exp_busy));
  endtask

  task automatic request(input logic [7:0] b);
    cmd_data      = b;
    tx_req_toggle = ~tx_req_toggle;
    #5;
  endtask

  task automatic idle_cycle();
    mouse_clk = 1'b0; #5;
    chk("idle_fall.oe_o", 32'(oe_o), 32'd0);
    chk_status("idle_fall", 1'b0);
    #15; mouse_clk = 1'b1; #5;
    chk_status("idle_rise", 1'b0);
    #15;
  endtask

  // One device-clocked frame. flip_at: falling edge after which the requester
  // flips again with nb (0 = none). abort_at: falling edge after which reset hits.
  task automatic do_frame(input logic [7:0] b, input bit nack, input int flip_at,
                          input int abort_at, input logic [7:0] nb);
    logic        lv, po, pe, exp_o, exp_e;
    logic [10:1] rx_o, rx_e;
    lv   = tx_req_toggle;
    po   = ~^b;
    pe   = ^b;
    rx_o = '0;
    rx_e = '0;
    chk("start.oe_o", 32'(oe_o), 32'd1);
    chk("start.oe_e", 32'(oe_e), 32'd1);
    chk_status("start", 1'b0);
    for (int k = 1; k <= 11; k++) begin
      mouse_clk = 1'b0; #5;
      if (k == abort_at) begin
        reset = 1'b1; tx_req_toggle = 1'b0; #1;
        m_done = 1'b0; m_err = 1'b0; m_fc = '0; m_ec = '0;
        chk("abort.oe_o", 32'(oe_o), 32'd0);
        chk("abort.oe_e", 32'(oe_e), 32'd0);
        chk_status("abort", 1'b0);
        #14; mouse_clk = 1'b1; #20;
        reset = 1'b0; #20;
        chk("post_abort.oe_o", 32'(oe_o), 32'd0);
        chk_status("post_abort", 1'b0);
        return;
      end
      if (k <= 8) begin
        exp_o = ~b[k-1]; exp_e = ~b[k-1];
      end else if (k == 9) begin
        exp_o = ~po; exp_e = ~pe;
      end else begin
        exp_o = 1'b0; exp_e = 1'b0;
      end
      chk($sformatf("fall%0d.oe_o", k), 32'(oe_o), 32'(exp_o));
      chk($sformatf("fall%0d.oe_e", k), 32'(oe_e), 32'(exp_e));
      if (k <= 10) begin
        oe_seen_o[k-1] = oe_o;
        oe_seen_e[k-1] = oe_e;
      end
      chk_status($sformatf("fall%0d", k), 1'b1);
      if (k == flip_at) begin
        tx_req_toggle = ~tx_req_toggle;
        cmd_data      = nb;
      end
      if (k == 11) dev_low = ~nack;
      #15; mouse_clk = 1'b1; #5;
      if (k <= 10) begin
        rx_o[k] = ~oe_o;
        rx_e[k] = ~oe_e;
        chk_status($sformatf("rise%0d", k), 1'b1);
      end else begin
        m_done = lv; m_err = nack; m_fc = m_fc + CW'(1);
        if (nack) m_ec = m_ec + CW'(1);
        dev_low = 1'b0;
        chk_status("ack", 1'b0);
        chk("ack.oe_o", 32'(oe_o), 32'(flip_at != 0));
      end
      #15;
    end
    chk("rx_byte_o", 32'(rx_o[8:1]), 32'(b));
    chk("rx_byte_e", 32'(rx_e[8:1]), 32'(b));
    chk("rx_par_o", 32'(^rx_o[9:1]), 32'd1);
    chk("rx_par_e", 32'(^rx_e[9:1]), 32'd0);
    chk("rx_stop_o", 32'(rx_o[10]), 32'd1);
  endtask

  initial begin
    logic [7:0] b, nb;
    bit         nack, chained;
    int         fa;
    vectors = 0; miscompares = 0;
    mouse_clk = 1'b1; reset = 1'b1; tx_req_toggle = 1'b0; cmd_data = 8'h00; dev_low = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_fc = '0; m_ec = '0;
    oe_seen_o = '0; oe_seen_e = '0;
    #7;
    chk("reset.oe_o", 32'(oe_o), 32'd0);
    chk_status("reset", 1'b0);
    #13; reset = 1'b0; #20;

    request(8'hF4);
    do_frame(8'hF4, 1'b0, 0, 0, 8'h00);
    chk("f4_oe_seq", 32'(oe_seen_o), 32'h10B);
    chk("f4_done", 32'(done_o), 32'd1);
    chk("f4_aerr", 32'(aerr_o), 32'd0);
    chk("f4_fc", 32'(fc_o), 32'd1);

    request(8'hFF);
    do_frame(8'hFF, 1'b0, 0, 0, 8'h00);
    chk("ff_oe_seq", 32'(oe_seen_o), 32'h000);

    request(8'hA5);
    do_frame(8'hA5, 1'b1, 0, 0, 8'h00);
    chk("nack_aerr", 32'(aerr_o), 32'd1);
    chk("nack_ec", 32'(ec_o), 32'd1);
    chk("nack_done", 32'(done_o), 32'(tx_req_toggle));

    request(8'hF4);
    do_frame(8'hF4, 1'b0, 11, 0, 8'hE8);
    chk("b2b_done1", 32'(done_o), 32'd0);
    do_frame(8'hE8, 1'b0, 0, 0, 8'h00);
    chk("b2b_done2", 32'(done_o), 32'd1);
    chk("b2b_fc", 32'(fc_o), 32'd5);

    request(8'h3C);
    do_frame(8'h3C, 1'b0, 0, 5, 8'h00);
    chk("abort_fc", 32'(fc_o), 32'd0);

    request(8'h01);
    do_frame(8'h01, 1'b0, 0, 0, 8'h00);
    chk("x01_oe_seq_o", 32'(oe_seen_o), 32'h1FE);
    chk("x01_oe_seq_e", 32'(oe_seen_e), 32'h0FE);
    chk("x01_done", 32'(done_e), 32'd1);
    chk("x01_fc", 32'(fc_e), 32'd1);

    chained = 1'b0;
    nb = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (!chained) begin
        b = 8'($urandom);
        request(b);
      end else begin
        b = nb;
      end
      nack = ($urandom_range(0, 3) == 0);
      fa   = (i < 29 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 0;
      nb   = 8'($urandom);
      do_frame(b, nack, fa, 0, nb);
      chained = (fa != 0);
      if (!chained && $urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
